// File: rtl/motion_pkg.sv
// Shared types and constants for the multi-channel motion sensor.
package motion_pkg;

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_MOTION = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0]  SSEG_DIGIT_MOTION = 4'h1;
  localparam logic [3:0]  SSEG_DIGIT_STABLE = 4'h0;
  localparam logic [15:0] BCD_MAX           = 16'h9999;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/motion_sensor_array_channel.sv
// One sensor channel: synchroniser, debounce filter and
// MOTION/HOLD/STABLE state machine with hold timer.
module motion_channel
  import motion_pkg::*;
#(
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic motion_detected,
  input  logic ch_enable,
  output logic state_motion,
  output logic motion_start
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HD_LAST = HW'(HOLD_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          filt;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  state_t        state;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      filt         <= 1'b0;
      db_cnt       <= '0;
      hold_cnt     <= '0;
      state        <= ST_STABLE;
      motion_start <= 1'b0;
    end else begin
      s1           <= motion_detected;
      s2           <= s1;
      motion_start <= 1'b0;
      if (!ch_enable) begin
        filt     <= 1'b0;
        db_cnt   <= '0;
        hold_cnt <= '0;
        state    <= ST_STABLE;
      end else begin
        if (s2 == filt) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          filt   <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
        // HOLD retrigger takes priority over hold expiry
        unique case (state)
          ST_STABLE: begin
            if (filt) begin
              state        <= ST_MOTION;
              motion_start <= 1'b1;
            end
          end
          ST_MOTION: begin
            if (!filt) begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
          end
          ST_HOLD: begin
            if (filt) begin
              state    <= ST_MOTION;
              hold_cnt <= '0;
            end else if (hold_cnt == HD_LAST) begin
              state <= ST_STABLE;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: state <= ST_STABLE;
        endcase
      end
    end
  end

  assign state_motion = (state != ST_STABLE);

endmodule

// File: rtl/motion_sensor_array.sv
// Multi-channel motion sensor with BCD event counter
// and seven-segment display value mux.
module motion_sensor_array
  import motion_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] motion_detected,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              disp_mode,
  input  logic              clear_count,
  output logic [NUM_CH-1:0] state_motion,
  output logic [NUM_CH-1:0] state_stable,
  output logic [NUM_CH-1:0] motion_start,
  output logic              any_motion,
  output logic [15:0]       event_count,
  output logic [15:0]       sseg_value
);

  logic [3:0] sm4;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    motion_channel #(
      .HOLD_CYCLES     (HOLD_CYCLES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .motion_detected (motion_detected[i]),
      .ch_enable       (ch_enable[i]),
      .state_motion    (state_motion[i]),
      .motion_start    (motion_start[i])
    );
  end

  assign state_stable = ~state_motion;
  assign any_motion   = |state_motion;

  // Simultaneous starts on several channels count once
  always_ff @(posedge clk) begin
    if (reset) begin
      event_count <= '0;
    end else if (clear_count) begin
      event_count <= '0;
    end else if (|motion_start && event_count != BCD_MAX) begin
      event_count <= bcd_inc(event_count);
    end
  end

  if (NUM_CH >= 4) begin : g_wide
    assign sm4 = state_motion[3:0];
  end else begin : g_narrow
    assign sm4 = {{(4-NUM_CH){1'b0}}, state_motion};
  end

  always_comb begin
    sseg_value = '0;
    if (disp_mode) begin
      sseg_value = event_count;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sseg_value[4*i +: 4] =
          sm4[i] ? SSEG_DIGIT_MOTION : SSEG_DIGIT_STABLE;
      end
    end
  end

endmodule

// File: tb/tb_motion_sensor_array.sv
// Directed testbench for motion_sensor_array.
module tb_motion_sensor_array;

  logic        clk;
  logic        reset;
  logic [3:0]  motion_detected;
  logic [3:0]  ch_enable;
  logic        disp_mode;
  logic        clear_count;
  logic [3:0]  state_motion;
  logic [3:0]  state_stable;
  logic [3:0]  motion_start;
  logic        any_motion;
  logic [15:0] event_count;
  logic [15:0] sseg_value;

  int vec;
  int miss;

  motion_sensor_array #(
    .NUM_CH          (4),
    .HOLD_CYCLES     (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .motion_detected (motion_detected),
    .ch_enable       (ch_enable),
    .disp_mode       (disp_mode),
    .clear_count     (clear_count),
    .state_motion    (state_motion),
    .state_stable    (state_stable),
    .motion_start    (motion_start),
    .any_motion      (any_motion),
    .event_count     (event_count),
    .sseg_value      (sseg_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One start on channel 1 (input held high) via disable/enable.
  // The count advances on the first edge of the next call or tick.
  task automatic pulse_events(input int n);
    for (int i = 0; i < n; i++) begin
      ch_enable[1] = 1'b0;
      tick(1);
      ch_enable[1] = 1'b1;
      tick(5);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    vec++;
    if (state_motion !== 4'h0 || state_stable !== 4'hF ||
        motion_start !== 4'h0 || any_motion !== 1'b0 ||
        event_count !== 16'h0 || sseg_value !== 16'h0) begin
      miss++;
      $display("FAIL reset_init: sm=%h ss=%h ms=%h am=%b ec=%h sv=%h",
               state_motion, state_stable, motion_start,
               any_motion, event_count, sseg_value);
    end
    reset = 1'b0;
    motion_detected[3] = 1'b1;
    tick(7);
    vec++;
    if (state_motion !== 4'h8 || any_motion !== 1'b1) begin
      miss++;
      $display("FAIL reset_pre: sm=%h am=%b want 8 1",
               state_motion, any_motion);
    end
    tick(1);
    reset = 1'b1;
    motion_detected[3] = 1'b0;
    tick(1);
    vec++;
    if (state_motion !== 4'h0 || state_stable !== 4'hF ||
        motion_start !== 4'h0 || event_count !== 16'h0 ||
        sseg_value !== 16'h0) begin
      miss++;
      $display("FAIL reset_mid: sm=%h ss=%h ms=%h ec=%h sv=%h",
               state_motion, state_stable, motion_start,
               event_count, sseg_value);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_rise;
    motion_detected[0] = 1'b1;
    tick(6);
    vec++;
    if (state_motion !== 4'h0 || motion_start !== 4'h0) begin
      miss++;
      $display("FAIL rise_early: sm=%h ms=%h want 0 0",
               state_motion, motion_start);
    end
    tick(1);
    vec++;
    if (state_motion !== 4'h1 || motion_start !== 4'h1 ||
        sseg_value !== 16'h0001 || event_count !== 16'h0) begin
      miss++;
      $display("FAIL rise_edge: sm=%h ms=%h sv=%h ec=%h want 1 1 0001 0000",
               state_motion, motion_start, sseg_value, event_count);
    end
    tick(1);
    vec++;
    if (motion_start !== 4'h0 || event_count !== 16'h0001) begin
      miss++;
      $display("FAIL rise_count: ms=%h ec=%h want 0 0001",
               motion_start, event_count);
    end
  endtask

  task automatic test_glitch_multi;
    logic bad;
    bad = 1'b0;
    motion_detected[1] = 1'b1;
    tick(3);
    motion_detected[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (state_motion !== 4'h1 || motion_start !== 4'h0 ||
          event_count !== 16'h0001 || sseg_value !== 16'h0001)
        bad = 1'b1;
    end
    vec++;
    if (bad) begin
      miss++;
      $display("FAIL glitch: sm=%h ms=%h ec=%h want 1 0 0001",
               state_motion, motion_start, event_count);
    end
    motion_detected[2:1] = 2'b11;
    tick(7);
    vec++;
    if (state_motion !== 4'h7 || motion_start !== 4'h6 ||
        sseg_value !== 16'h0111) begin
      miss++;
      $display("FAIL multi_start: sm=%h ms=%h sv=%h want 7 6 0111",
               state_motion, motion_start, sseg_value);
    end
    tick(1);
    vec++;
    if (event_count !== 16'h0002) begin
      miss++;
      $display("FAIL multi_count: ec=%h want 0002", event_count);
    end
  endtask

  task automatic test_hold;
    logic bad;
    motion_detected[0] = 1'b0;
    tick(16);
    vec++;
    if (state_motion[0] !== 1'b1) begin
      miss++;
      $display("FAIL hold_keep: sm0=%b want 1", state_motion[0]);
    end
    tick(1);
    vec++;
    if (state_motion[0] !== 1'b0 || state_stable[0] !== 1'b1) begin
      miss++;
      $display("FAIL hold_fall: sm0=%b ss0=%b want 0 1",
               state_motion[0], state_stable[0]);
    end
    motion_detected[0] = 1'b1;
    tick(7);
    vec++;
    if (motion_start[0] !== 1'b1) begin
      miss++;
      $display("FAIL hold_restart: ms0=%b want 1", motion_start[0]);
    end
    tick(2);
    motion_detected[0] = 1'b0;
    tick(8);
    motion_detected[0] = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (state_motion[0] !== 1'b1 || motion_start[0] !== 1'b0)
        bad = 1'b1;
    end
    vec++;
    if (bad) begin
      miss++;
      $display("FAIL retrigger: sm0=%b ms0=%b want 1 0",
               state_motion[0], motion_start[0]);
    end
  endtask

  task automatic test_counter;
    clear_count = 1'b1;
    tick(1);
    clear_count = 1'b0;
    vec++;
    if (event_count !== 16'h0000) begin
      miss++;
      $display("FAIL clear: ec=%h want 0000", event_count);
    end
    pulse_events(9);
    tick(1);
    vec++;
    if (event_count !== 16'h0009) begin
      miss++;
      $display("FAIL cnt_9: ec=%h want 0009", event_count);
    end
    pulse_events(1);
    tick(1);
    vec++;
    if (event_count !== 16'h0010) begin
      miss++;
      $display("FAIL cnt_10: ec=%h want 0010", event_count);
    end
    pulse_events(89);
    tick(1);
    vec++;
    if (event_count !== 16'h0099) begin
      miss++;
      $display("FAIL cnt_99: ec=%h want 0099", event_count);
    end
    pulse_events(1);
    tick(1);
    vec++;
    if (event_count !== 16'h0100) begin
      miss++;
      $display("FAIL cnt_100: ec=%h want 0100", event_count);
    end
    pulse_events(9899);
    tick(1);
    disp_mode = 1'b1;
    #1;
    vec++;
    if (event_count !== 16'h9999 || sseg_value !== 16'h9999) begin
      miss++;
      $display("FAIL cnt_max: ec=%h sv=%h want 9999 9999",
               event_count, sseg_value);
    end
    pulse_events(1);
    tick(1);
    vec++;
    if (event_count !== 16'h9999) begin
      miss++;
      $display("FAIL cnt_sat: ec=%h want 9999", event_count);
    end
    ch_enable[1] = 1'b0;
    tick(1);
    ch_enable[1] = 1'b1;
    tick(5);
    clear_count = 1'b1;
    vec++;
    if (motion_start[1] !== 1'b1) begin
      miss++;
      $display("FAIL clr_setup: ms1=%b want 1", motion_start[1]);
    end
    tick(1);
    clear_count = 1'b0;
    vec++;
    if (event_count !== 16'h0000 || sseg_value !== 16'h0000) begin
      miss++;
      $display("FAIL clr_wins: ec=%h sv=%h want 0000 0000",
               event_count, sseg_value);
    end
    disp_mode = 1'b0;
    tick(2);
  endtask

  task automatic test_disable;
    ch_enable[0] = 1'b0;
    tick(1);
    vec++;
    if (state_motion[0] !== 1'b0 || sseg_value[3:0] !== 4'h0 ||
        motion_start[0] !== 1'b0) begin
      miss++;
      $display("FAIL dis_now: sm0=%b nib0=%h ms0=%b want 0 0 0",
               state_motion[0], sseg_value[3:0], motion_start[0]);
    end
    tick(3);
    ch_enable[0] = 1'b1;
    tick(4);
    vec++;
    if (state_motion[0] !== 1'b0 || motion_start[0] !== 1'b0) begin
      miss++;
      $display("FAIL reen_early: sm0=%b ms0=%b want 0 0",
               state_motion[0], motion_start[0]);
    end
    tick(1);
    vec++;
    if (state_motion[0] !== 1'b1 || motion_start[0] !== 1'b1 ||
        sseg_value[3:0] !== 4'h1) begin
      miss++;
      $display("FAIL reen_start: sm0=%b ms0=%b nib0=%h want 1 1 1",
               state_motion[0], motion_start[0], sseg_value[3:0]);
    end
  endtask

  initial begin
    vec             = 0;
    miss            = 0;
    reset           = 1'b1;
    motion_detected = 4'h0;
    ch_enable       = 4'hF;
    disp_mode       = 1'b0;
    clear_count     = 1'b0;
    test_reset;
    test_rise;
    test_glitch_multi;
    test_hold;
    test_counter;
    test_disable;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
